bp_out_wb_ctrl: RTL and testbench

Writeback streamer for the bit-parallel DSP core's output buffers: it is the transmit side of the core's `bp_out_wb_data` path, mirroring the AXI-stream load side. On a start command it sweeps output-buffer addresses and column groups, driving the core's writeback read controls. It captures the registered 128-bit words that return after a fixed read latency and emits them as an AXI-stream master with full backpressure. It sits between `bp_dsp_core` and the output DMA/stream interconnect.

---
 rtl/bp_out_wb_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_bp_out_wb_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_out_wb_ctrl.sv
// bp_out_wb_ctrl: sweeps output-buffer addresses and column groups, captures the
// returning writeback words and streams them out over AXI-stream with backpressure.
//
// state | meaning
// IDLE  | waiting for wb_start; latches count and bank
// ISSUE | one read per cycle while FIFO + in-flight credit remains
// DRAIN | all reads issued (or none requested); wait for FIFO empty, nothing in flight
// DONE  | one-cycle wb_done pulse, then back to IDLE
//
// A zero-address start passes through DRAIN, which exits at once, so wb_done
// lands two cycles after start.
module bp_out_wb_ctrl #(
  parameter int BP_COLS          = 18,
  parameter int BP_OUT_BUF_DEPTH = 9,
  parameter int NUM_GRP          = 2,
  parameter int RD_LAT           = 2,
  parameter int EN_DLY           = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  wb_start,
  input  logic [BP_OUT_BUF_DEPTH:0]             wb_num_addr,
  input  logic                                  wb_buf_sel,
  output logic                                  wb_busy,
  output logic                                  wb_done,
  output logic [2:0]                            bp_out_buf_wb_en,
  output logic [BP_COLS*BP_OUT_BUF_DEPTH-1:0]   bp_out_buf_wb_addr,
  output logic                                  bp_out_buf_wb_sel,
  input  logic [127:0]                          bp_out_wb_data,
  output logic [127:0]                          m_axis_bp_out_tdata,
  output logic                                  m_axis_bp_out_tvalid,
  input  logic                                  m_axis_bp_out_tready,
  output logic                                  m_axis_bp_out_tlast
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int AW = BP_OUT_BUF_DEPTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [AW-1:0]          num_addr;
  logic [AW-1:0]          addr_cnt;
  logic [2:0]             grp_cnt;
  logic                   buf_sel;
  logic [CW-1:0]          fifo_cnt;
  logic [CW-1:0]          inflight;
  logic                   credit_ok, issue, last_issue, push, pop, drain_ok;
  logic [RD_LAT-1:0]      rd_vld;
  logic [RD_LAT-1:0]      rd_last;
  logic [EN_DLY-1:0]      en_vld;
  logic [2:0]             en_grp [EN_DLY];
  logic [2:0]             en_hold;
  logic [127:0]           mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  mem_last;
  logic [PW-1:0]          wr_ptr, rd_ptr;

  assign credit_ok  = ({1'b0, fifo_cnt} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
  assign last_issue = (addr_cnt == num_addr - 1'b1) && (grp_cnt == 3'(NUM_GRP - 1));
  assign push       = rd_vld[RD_LAT-1];
  assign pop        = m_axis_bp_out_tvalid && m_axis_bp_out_tready;
  assign drain_ok   = (inflight == '0) && !push &&
                      ((fifo_cnt == '0) || ((fifo_cnt == CW'(1)) && pop));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and issue strobe
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (wb_start) state_nxt = (wb_num_addr == '0) ? DRAIN : ISSUE;
      end
      ISSUE: begin
        issue = credit_ok;
        if (credit_ok && last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_ok) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wb_busy = (state == ISSUE) || (state == DRAIN);
  assign wb_done = (state == DONE);

  // sweep counters: group-minor, address-major; hold the last address after the sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_addr <= '0;
      addr_cnt <= '0;
      grp_cnt  <= '0;
      buf_sel  <= 1'b0;
    end else if ((state == IDLE) && wb_start) begin
      num_addr <= wb_num_addr;
      addr_cnt <= '0;
      grp_cnt  <= '0;
      buf_sel  <= wb_buf_sel;
    end else if (issue && !last_issue) begin
      if (grp_cnt == 3'(NUM_GRP - 1)) begin
        grp_cnt  <= '0;
        addr_cnt <= addr_cnt + 1'b1;
      end else begin
        grp_cnt <= grp_cnt + 1'b1;
      end
    end
  end

  assign bp_out_buf_wb_addr = {BP_COLS{addr_cnt[BP_OUT_BUF_DEPTH-1:0]}};
  assign bp_out_buf_wb_sel  = buf_sel;

  // in-flight reads: issue and return may coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({issue, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // read-latency and group-enable shift lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld  <= '0;
      rd_last <= '0;
      en_vld  <= '0;
      for (int i = 0; i < EN_DLY; i++) en_grp[i] <= '0;
      en_hold <= '0;
    end else begin
      for (int i = RD_LAT-1; i > 0; i--) begin
        rd_vld[i]  <= rd_vld[i-1];
        rd_last[i] <= rd_last[i-1];
      end
      rd_vld[0]  <= issue;
      rd_last[0] <= issue && last_issue;
      for (int i = EN_DLY-1; i > 0; i--) begin
        en_vld[i] <= en_vld[i-1];
        en_grp[i] <= en_grp[i-1];
      end
      en_vld[0] <= issue;
      en_grp[0] <= grp_cnt;
      en_hold   <= bp_out_buf_wb_en;
    end
  end

  assign bp_out_buf_wb_en = en_vld[EN_DLY-1] ? en_grp[EN_DLY-1] : en_hold;

  // first-word-fall-through skid FIFO; credit keeps it from overflowing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_data[i] <= '0;
      mem_last <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= bp_out_wb_data;
        mem_last[wr_ptr] <= rd_last[RD_LAT-1];
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign m_axis_bp_out_tvalid = (fifo_cnt != '0);
  assign m_axis_bp_out_tdata  = mem_data[rd_ptr];
  assign m_axis_bp_out_tlast  = m_axis_bp_out_tvalid && mem_last[rd_ptr];

endmodule

// File: tb/tb_bp_out_wb_ctrl.sv
// tb_bp_out_wb_ctrl: directed bench for the writeback streamer with a small core read model.
module tb_bp_out_wb_ctrl;
  localparam int BP_COLS    = 18;
  localparam int DEP        = 9;
  localparam int NUM_GRP    = 2;
  localparam int RD_LAT     = 2;
  localparam int EN_DLY     = 1;
  localparam int FIFO_DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   wb_start = 1'b0;
  logic [DEP:0]           wb_num_addr = '0;
  logic                   wb_buf_sel = 1'b0;
  logic                   wb_busy, wb_done;
  logic [2:0]             wb_en;
  logic [BP_COLS*DEP-1:0] wb_addr;
  logic                   wb_sel;
  logic [127:0]           wb_data = '0;
  logic [127:0]           tdata;
  logic                   tvalid, tlast;
  logic                   tready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bp_out_wb_ctrl #(
    .BP_COLS(BP_COLS), .BP_OUT_BUF_DEPTH(DEP), .NUM_GRP(NUM_GRP),
    .RD_LAT(RD_LAT), .EN_DLY(EN_DLY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wb_start(wb_start), .wb_num_addr(wb_num_addr),
    .wb_buf_sel(wb_buf_sel), .wb_busy(wb_busy), .wb_done(wb_done),
    .bp_out_buf_wb_en(wb_en), .bp_out_buf_wb_addr(wb_addr), .bp_out_buf_wb_sel(wb_sel),
    .bp_out_wb_data(wb_data), .m_axis_bp_out_tdata(tdata), .m_axis_bp_out_tvalid(tvalid),
    .m_axis_bp_out_tready(tready), .m_axis_bp_out_tlast(tlast)
  );

  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // core model: registered word addr*2+group, valid RD_LAT cycles after the address
  logic [DEP-1:0] core_a = '0;
  always @(posedge clk) begin
    core_a  <= wb_addr[DEP-1:0];
    wb_data <= 128'(core_a) * 128'd2 + 128'(wb_en);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [127:0] rx_data[$];
  bit           rx_last[$];
  int           rx_cyc[$];
  int           done_cyc, done_cnt, issue_cnt, tvalid_cnt;
  bit           done_seen, busy_at_done;
  bit           prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic         prev_last;

  // stream monitor on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        check("occ_le_depth", 128'(dut.fifo_cnt <= 3'(FIFO_DEPTH)), 128'(1));
        if (prev_stall) begin
          check("hold_valid", 128'(tvalid), 128'(1));
          check("hold_data", tdata, prev_data);
          check("hold_last", 128'(tlast), 128'(prev_last));
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_last  = tlast;
        if (tvalid) tvalid_cnt++;
        if (tvalid && tready) begin
          rx_data.push_back(tdata);
          rx_last.push_back(tlast);
          rx_cyc.push_back(cyc);
        end
        if (dut.issue) issue_cnt++;
        if (wb_done) begin
          done_cnt++;
          done_seen    = 1'b1;
          done_cyc     = cyc;
          busy_at_done = wb_busy;
        end
      end
    end
  end

  task automatic clear_log();
    rx_data.delete();
    rx_last.delete();
    rx_cyc.delete();
    done_cnt = 0; issue_cnt = 0; tvalid_cnt = 0;
    done_seen = 1'b0; busy_at_done = 1'b1; done_cyc = -1;
  endtask

  task automatic do_start(input int num, input bit s, output int st);
    @(posedge clk); #1;
    wb_num_addr = (DEP+1)'(num);
    wb_buf_sel  = s;
    wb_start    = 1'b1;
    st          = cyc;
    @(posedge clk); #1;
    wb_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done_seen && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 128'(done_seen), 128'(1));
    repeat (2) @(posedge clk);
  endtask

  task automatic check_stream(input int n, input string tag);
    check({tag, "_beats"}, 128'(rx_data.size()), 128'(n));
    for (int k = 0; k < rx_data.size() && k < n; k++) begin
      check({tag, "_data"}, rx_data[k], 128'(k));
      check({tag, "_last"}, 128'(rx_last[k]), 128'(k == n - 1));
    end
    if (rx_cyc.size() > 0)
      check({tag, "_done_lat"}, 128'(done_cyc), 128'(rx_cyc[rx_cyc.size()-1] + 1));
    check({tag, "_busy_at_done"}, 128'(busy_at_done), 128'(0));
    check({tag, "_done_cnt"}, 128'(done_cnt), 128'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st;
    int n;
    int exp_a[6];
    int exp_e[6];
    int a_log[7];
    int e_log[7];
    logic [BP_COLS*DEP-1:0] full_addr;
    exp_a = '{0, 0, 1, 1, 2, 2};
    exp_e = '{0, 1, 0, 1, 0, 1};

    clear_log();
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy",   128'(wb_busy), 128'(0));
    check("rst_done",   128'(wb_done), 128'(0));
    check("rst_tvalid", 128'(tvalid),  128'(0));
    check("rst_tlast",  128'(tlast),   128'(0));
    check("rst_en",     128'(wb_en),   128'(0));
    check("rst_addr",   128'(wb_addr), 128'(0));
    check("rst_sel",    128'(wb_sel),  128'(0));
    check("rst_tdata",  tdata,         128'(0));

    // basic sweep, three addresses
    clear_log();
    tready = 1'b1;
    do_start(3, 1'b1, st);
    @(negedge clk);
    check("basic_busy", 128'(wb_busy), 128'(1));
    check("basic_sel",  128'(wb_sel),  128'(1));
    for (int i = 0; i < 7; i++) begin
      a_log[i] = int'(wb_addr[DEP-1:0]);
      e_log[i] = int'(wb_en);
      if (i == 2) full_addr = wb_addr;
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      check("basic_addr", 128'(a_log[i]), 128'(exp_a[i]));
      check("basic_en",   128'(e_log[i+1]), 128'(exp_e[i]));
    end
    check("basic_addr_all_cols", 128'(full_addr), 128'({BP_COLS{9'd1}}));
    wait_done(50, "basic");
    check_stream(6, "basic");
    if (rx_cyc.size() > 0) check("basic_first_lat", 128'(rx_cyc[0]), 128'(st + 4));
    for (int k = 1; k < rx_cyc.size(); k++)
      check("basic_no_bubble", 128'(rx_cyc[k]), 128'(rx_cyc[k-1] + 1));

    // zero count
    clear_log();
    do_start(0, 1'b0, st);
    wait_done(20, "zero");
    check("zero_tvalid", 128'(tvalid_cnt), 128'(0));
    check("zero_done_lat", 128'(done_cyc), 128'(st + 2));
    check("zero_done_cnt", 128'(done_cnt), 128'(1));

    // backpressure: tready low for 10 cycles after start
    clear_log();
    tready = 1'b0;
    do_start(8, 1'b0, st);
    repeat (10) @(posedge clk);
    #1;
    check("bp_issue_stall", 128'(issue_cnt), 128'(FIFO_DEPTH));
    check("bp_no_beats", 128'(rx_data.size()), 128'(0));
    tready = 1'b1;
    wait_done(100, "bp");
    check_stream(16, "bp");

    // random tready, 64 addresses
    clear_log();
    do_start(64, 1'b1, st);
    n = 0;
    while (!done_seen && n < 3000) begin
      @(posedge clk); #1;
      tready = 1'($urandom_range(0, 1));
      n++;
    end
    check("rand_done_seen", 128'(done_seen), 128'(1));
    tready = 1'b1;
    repeat (2) @(posedge clk);
    check_stream(128, "rand");

    // second start while busy is ignored
    clear_log();
    tready = 1'b1;
    do_start(4, 1'b0, st);
    repeat (2) @(posedge clk);
    #1;
    wb_num_addr = (DEP+1)'(10);
    wb_start = 1'b1;
    @(posedge clk); #1;
    wb_start = 1'b0;
    wait_done(100, "busy_start");
    check_stream(8, "busy_start");

    // async reset mid-sweep
    clear_log();
    do_start(4, 1'b1, st);
    n = 0;
    while (rx_data.size() < 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("arst_reached_beat3", 128'(rx_data.size() >= 3), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",   128'(wb_busy), 128'(0));
    check("arst_done",   128'(wb_done), 128'(0));
    check("arst_tvalid", 128'(tvalid),  128'(0));
    check("arst_tlast",  128'(tlast),   128'(0));
    check("arst_en",     128'(wb_en),   128'(0));
    check("arst_addr",   128'(wb_addr), 128'(0));
    check("arst_sel",    128'(wb_sel),  128'(0));
    check("arst_tdata",  tdata,         128'(0));
    clear_log();
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    check("arst_no_beats", 128'(rx_data.size()), 128'(0));
    check("arst_no_done",  128'(done_cnt), 128'(0));
    clear_log();
    do_start(4, 1'b0, st);
    wait_done(100, "arst_restart");
    check_stream(8, "arst_restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
